// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter and sequencer that shares one start/done arithmetic unit among N_REQ
// requesters, with a watchdog that clears a hung unit and returns an error response.
module fp_unit_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   u_start,
    output logic [WIDTH-1:0]       u_A,
    output logic [WIDTH-1:0]       u_B,
    output logic                   u_clear,
    input  logic                   u_done,
    input  logic [WIDTH-1:0]       u_out
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_idx_s, cand_s;
    logic             sel_found_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic             u_start_q, u_start_d;
    logic             u_clear_q, u_clear_d;
    logic [WIDTH-1:0] u_a_q, u_a_d;
    logic [WIDTH-1:0] u_b_q, u_b_d;

    // Round-robin pick: first set request at or above ptr, wrapping around.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        // Walk downward so the closest candidate to ptr is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_s = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (req[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        u_a_d       = u_a_q;
        u_b_d       = u_b_q;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        u_clear_d   = 1'b0;
        gnt_d       = '0;
        rsp_valid_d = '0;
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    state_d = ISSUE;
                    idx_d   = sel_idx_s;
                    u_a_d   = a_in[sel_idx_s*WIDTH +: WIDTH];
                    u_b_d   = b_in[sel_idx_s*WIDTH +: WIDTH];
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // The clear cycle is the final WAIT cycle; a done arriving then is stale.
                if (u_clear_q) begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else if (u_done) begin
                    rsp_data_d = u_out;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    u_clear_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != IDLE) begin
            gnt_d[idx_d] = 1'b1;
        end else begin
            gnt_d = '0;
        end
        if (state_d == RESP) begin
            rsp_valid_d[idx_d] = 1'b1;
        end else begin
            rsp_valid_d = '0;
        end
        u_start_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            u_start_q   <= 1'b0;
            u_clear_q   <= 1'b0;
            u_a_q       <= '0;
            u_b_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            u_start_q   <= u_start_d;
            u_clear_q   <= u_clear_d;
            u_a_q       <= u_a_d;
            u_b_q       <= u_b_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign u_start   = u_start_q;
    assign u_clear   = u_clear_q;
    assign u_A       = u_a_q;
    assign u_B       = u_b_q;

endmodule
